// File: rtl/controleur_compteur_pkg.sv
`default_nettype none
// ============================================================================
// Module      : controleur_compteur_pkg
// Description : Shared types and constants for the 0..999 counter controller.
//               etat_t      - controller states (encoding is visible on Etat)
//               LARGEUR     - signed width of the counter datapath
//               VAL_MAX_DEFAUT - default upper legal counter value
//               hors_plage  - 1 when a value lies outside 0..vmax
// Revision    : 1.0 - initial release
// ============================================================================
package controleur_compteur_pkg;

    localparam int LARGEUR        = 12;
    localparam int VAL_MAX_DEFAUT = 999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAUT   = 2'd1,
        BAS    = 2'd2,
        DEFAUT = 2'd3
    } etat_t;

    function automatic logic hors_plage(
        input logic signed [LARGEUR-1:0] val,
        input logic signed [LARGEUR-1:0] vmax
    );
        return (val < 0) || (val > vmax);
    endfunction

endpackage
`default_nettype wire

// File: rtl/controleur_compteur_diviseur_tick.sv
`default_nettype none
// ============================================================================
// Module      : diviseur_tick
// Description : Step prescaler. Counts 0..TICK_DIV-1 while actif is high and
//               raises tick during the cycle the count equals TICK_DIV-1.
//   clk     in  : clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   effacer in  : synchronous clear, forces the count back to 0
//   actif   in  : counting enable (controller is stepping up or down)
//   tick    out : one-cycle step request (combinational from the count)
// Revision    : 1.0 - initial release
// ============================================================================
module diviseur_tick #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic effacer,
    input  logic actif,
    output logic tick
);

    localparam int         LARG    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [LARG-1:0] DERNIER = LARG'(TICK_DIV - 1);

    logic [LARG-1:0] compte;

    assign tick = actif && (compte == DERNIER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            compte <= '0;
        end else if (effacer || !actif || tick) begin
            compte <= '0;
        end else begin
            compte <= compte + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/controleur_compteur.sv
`default_nettype none
// ============================================================================
// Module      : controleur_compteur
// Description : Sequencing controller for the 0..VAL_MAX up/down counter.
//               Arbitrates Effacer > Charger > direction buttons, steps the
//               counter every TICK_DIV cycles, saturates or wraps at limits
//               and flags loaded values outside the legal range.
//   Clk                in  : clock, rising edge
//   Reset_n            in  : asynchronous active-low reset
//   BoutonHaut         in  : level, hold to count up
//   BoutonBas          in  : level, hold to count down
//   Charger            in  : load strobe
//   ValeurCharge       in  : signed value loaded on Charger
//   Effacer            in  : clear strobe
//   Compteurs          out : registered signed counter value
//   CompteursHorsPlage out : registered, Compteurs outside 0..VAL_MAX
//   Limite             out : registered pulse on a step that hits a limit
//   Etat               out : current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module controleur_compteur
    import controleur_compteur_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int VAL_MAX  = VAL_MAX_DEFAUT,
    parameter bit WRAP     = 1'b0
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      BoutonHaut,
    input  logic                      BoutonBas,
    input  logic                      Charger,
    input  logic signed [LARGEUR-1:0] ValeurCharge,
    input  logic                      Effacer,
    output logic signed [LARGEUR-1:0] Compteurs,
    output logic                      CompteursHorsPlage,
    output logic                      Limite,
    output logic [1:0]                Etat
);

    localparam logic signed [LARGEUR-1:0] MAXV = LARGEUR'(VAL_MAX);

    etat_t                      etat;
    etat_t                      etat_suiv;
    logic                       actif;
    logic                       tick;
    logic                       pas;
    logic                       raz_diviseur;
    logic signed [LARGEUR-1:0]  valeur_suiv;
    logic                       limite_suiv;
    logic                       hors_plage_suiv;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            etat <= IDLE;
        end else begin
            etat <= etat_suiv;
        end
    end

    // Next-state logic: clear beats load beats the buttons; DEFAUT only
    // leaves through a clear or a load.
    always_comb begin
        etat_suiv = etat;
        if (Effacer) begin
            etat_suiv = IDLE;
        end else if (Charger) begin
            etat_suiv = hors_plage(ValeurCharge, MAXV) ? DEFAUT : IDLE;
        end else if (etat != DEFAUT) begin
            case ({BoutonHaut, BoutonBas})
                2'b10:   etat_suiv = HAUT;
                2'b01:   etat_suiv = BAS;
                default: etat_suiv = IDLE;
            endcase
        end
    end

    // State outputs
    always_comb begin
        actif = (etat == HAUT) || (etat == BAS);
        Etat  = etat;
    end

    // Any state change (including a reversal) or a load/clear restarts the
    // prescaler so the next step lands TICK_DIV cycles later.
    assign raz_diviseur = Effacer || Charger || (etat_suiv != etat);

    diviseur_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_diviseur (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .effacer (raz_diviseur),
        .actif   (actif),
        .tick    (tick)
    );

    // A step is only taken when the controller stays in its direction.
    assign pas = tick && (etat_suiv == etat) && !Effacer && !Charger;

    // Counter datapath
    always_comb begin
        valeur_suiv = Compteurs;
        limite_suiv = 1'b0;
        if (Effacer) begin
            valeur_suiv = '0;
        end else if (Charger) begin
            valeur_suiv = ValeurCharge;
        end else if (pas && (etat == HAUT)) begin
            if (Compteurs >= MAXV) begin
                limite_suiv = 1'b1;
                valeur_suiv = WRAP ? '0 : MAXV;
            end else begin
                valeur_suiv = Compteurs + 12'sd1;
            end
        end else if (pas && (etat == BAS)) begin
            if (Compteurs <= 12'sd0) begin
                limite_suiv = 1'b1;
                valeur_suiv = WRAP ? MAXV : '0;
            end else begin
                valeur_suiv = Compteurs - 12'sd1;
            end
        end
        hors_plage_suiv = hors_plage(valeur_suiv, MAXV);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Compteurs          <= '0;
            CompteursHorsPlage <= 1'b0;
            Limite             <= 1'b0;
        end else begin
            Compteurs          <= valeur_suiv;
            CompteursHorsPlage <= hors_plage_suiv;
            Limite             <= limite_suiv;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controleur_compteur.sv
`default_nettype none
// ============================================================================
// Module      : tb_controleur_compteur
// Description : Self-checking bench. Two controllers share the stimulus:
//               a slow saturating one (TICK_DIV=4, WRAP=0) and a fast
//               wrapping one (TICK_DIV=1, WRAP=1). A behavioural model tracks
//               each one and is compared on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controleur_compteur;

    logic               Clk;
    logic               Reset_n;
    logic               BoutonHaut;
    logic               BoutonBas;
    logic               Charger;
    logic signed [11:0] ValeurCharge;
    logic               Effacer;

    logic signed [11:0] c0, c1;
    logic               hp0, hp1;
    logic               l0, l1;
    logic [1:0]         e0, e1;

    int checks = 0;
    int errors = 0;

    controleur_compteur #(.TICK_DIV(4), .VAL_MAX(999), .WRAP(1'b0)) dut_lent (
        .Clk(Clk), .Reset_n(Reset_n), .BoutonHaut(BoutonHaut), .BoutonBas(BoutonBas),
        .Charger(Charger), .ValeurCharge(ValeurCharge), .Effacer(Effacer),
        .Compteurs(c0), .CompteursHorsPlage(hp0), .Limite(l0), .Etat(e0)
    );

    controleur_compteur #(.TICK_DIV(1), .VAL_MAX(999), .WRAP(1'b1)) dut_rapide (
        .Clk(Clk), .Reset_n(Reset_n), .BoutonHaut(BoutonHaut), .BoutonBas(BoutonBas),
        .Charger(Charger), .ValeurCharge(ValeurCharge), .Effacer(Effacer),
        .Compteurs(c1), .CompteursHorsPlage(hp1), .Limite(l1), .Etat(e1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    // st: 0 idle, 1 up, 2 down, 3 fault. n: edges spent in the current
    // direction since entering it; a step falls on every td-th such edge.
    typedef struct packed {
        int   val;
        int   st;
        int   n;
        logic flag;
        logic lim;
    } mstate_t;

    mstate_t m0, m1;

    function automatic mstate_t step_model(mstate_t m, int td, bit wr,
                                           logic eff, logic chg, int vc,
                                           logic h, logic b);
        mstate_t r = m;
        int ns;
        r.lim = 1'b0;
        if (eff) begin
            r.val = 0; r.flag = 1'b0; r.st = 0; r.n = 0;
        end else if (chg) begin
            r.val  = vc;
            r.flag = (vc < 0) || (vc > 999);
            r.st   = r.flag ? 3 : 0;
            r.n    = 0;
        end else if (m.st != 3) begin
            ns = (h && !b) ? 1 : ((b && !h) ? 2 : 0);
            if (ns != m.st) begin
                r.st = ns; r.n = 0;
            end else if (ns != 0) begin
                r.n = m.n + 1;
                if (r.n % td == 0) begin
                    if (ns == 1) begin
                        if (m.val == 999) begin r.lim = 1'b1; r.val = wr ? 0 : 999; end
                        else r.val = m.val + 1;
                    end else begin
                        if (m.val == 0) begin r.lim = 1'b1; r.val = wr ? 999 : 0; end
                        else r.val = m.val - 1;
                    end
                end
            end
        end
        return r;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= step_model(m0, 4, 1'b0, Effacer, Charger, int'(ValeurCharge), BoutonHaut, BoutonBas);
            m1 <= step_model(m1, 1, 1'b1, Effacer, Charger, int'(ValeurCharge), BoutonHaut, BoutonBas);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model
    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("lent.Compteurs", int'(c0), m0.val);
            chk("lent.HorsPlage", int'(hp0), int'(m0.flag));
            chk("lent.Limite", int'(l0), int'(m0.lim));
            chk("lent.Etat", int'(e0), m0.st);
            chk("rapide.Compteurs", int'(c1), m1.val);
            chk("rapide.HorsPlage", int'(hp1), int'(m1.flag));
            chk("rapide.Limite", int'(l1), int'(m1.lim));
            chk("rapide.Etat", int'(e1), m1.st);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int tmp;
        Reset_n = 1'b0; BoutonHaut = 1'b0; BoutonBas = 1'b0;
        Charger = 1'b0; Effacer = 1'b0; ValeurCharge = '0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("reset.Compteurs", int'(c0), 0);
        chk("reset.Etat", int'(e0), 0);
        chk("reset.Limite", int'(l0), 0);

        // Hold up for 41 edges: slow unit steps on edges 5,9..41, fast on 2..41
        BoutonHaut = 1'b1;
        repeat (41) @(negedge Clk);
        chk("hold_up.lent", int'(c0), 10);
        chk("hold_up.rapide", int'(c1), 40);
        BoutonHaut = 1'b0;
        @(negedge Clk);

        // Load 998 then climb into the upper limit
        Charger = 1'b1; ValeurCharge = 12'sd998;
        @(negedge Clk);
        Charger = 1'b0; BoutonHaut = 1'b1;
        repeat (13) @(negedge Clk);
        chk("sat.lent.val", int'(c0), 999);
        chk("sat.lent.limite", int'(l0), 1);
        chk("sat.lent.flag", int'(hp0), 0);
        chk("wrap.rapide.val", int'(c1), 10);
        BoutonHaut = 1'b0;
        @(negedge Clk);

        // Load 0 then step down: the wrapping unit rolls to 999
        Charger = 1'b1; ValeurCharge = 12'sd0;
        @(negedge Clk);
        Charger = 1'b0; BoutonBas = 1'b1;
        repeat (2) @(negedge Clk);
        chk("wrap_down.val", int'(c1), 999);
        chk("wrap_down.limite", int'(l1), 1);
        chk("wrap_down.lent.etat", int'(e0), 2);
        BoutonBas = 1'b0;
        @(negedge Clk);

        // Out-of-range loads
        Charger = 1'b1; ValeurCharge = -12'sd5;
        @(negedge Clk);
        Charger = 1'b0;
        chk("neg.etat", int'(e0), 3);
        chk("neg.flag", int'(hp0), 1);
        chk("neg.val", int'(c0), -5);
        BoutonHaut = 1'b1;
        repeat (6) @(negedge Clk);
        chk("defaut.ignore.val", int'(c1), -5);
        BoutonHaut = 1'b0;
        Charger = 1'b1; ValeurCharge = 12'sd1200;
        @(negedge Clk);
        chk("big.etat", int'(e0), 3);
        ValeurCharge = 12'sd500;
        @(negedge Clk);
        Charger = 1'b0;
        chk("valid.etat", int'(e0), 0);
        chk("valid.flag", int'(hp0), 0);

        // Both buttons: stay idle, value unchanged
        BoutonHaut = 1'b1; BoutonBas = 1'b1;
        repeat (6) @(negedge Clk);
        chk("both.etat", int'(e1), 0);
        chk("both.val", int'(c1), 500);
        BoutonHaut = 1'b0; BoutonBas = 1'b0;

        // Clear beats load
        Charger = 1'b1; Effacer = 1'b1; ValeurCharge = 12'sd321;
        @(negedge Clk);
        Charger = 1'b0; Effacer = 1'b0;
        chk("clr_vs_load.lent", int'(c0), 0);
        chk("clr_vs_load.rapide", int'(c1), 0);

        // Asynchronous reset between clock edges while counting
        BoutonHaut = 1'b1;
        repeat (10) @(negedge Clk);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("async.rapide.val", int'(c1), 0);
        chk("async.rapide.etat", int'(e1), 0);
        chk("async.lent.val", int'(c0), 0);
        chk("async.lent.etat", int'(e0), 0);
        BoutonHaut = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            tmp = $urandom_range(0, 99);
            Effacer = (tmp < 2);
            Charger = (tmp >= 2) && (tmp < 6);
            case ($urandom_range(0, 4))
                0:       tmp = 999;
                1:       tmp = 0;
                2:       tmp = 998;
                default: tmp = int'($urandom_range(0, 1150)) - 60;
            endcase
            ValeurCharge = tmp[11:0];
            if ($urandom_range(0, 9) == 0) begin
                BoutonHaut = 1'($urandom_range(0, 1));
                BoutonBas  = 1'($urandom_range(0, 1));
            end
            @(negedge Clk);
        end
        Charger = 1'b0; Effacer = 1'b0;
        @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controleur_compteur.md
# controleur_compteur

Sequencing controller for the 0..999 up/down counter datapath. It arbitrates between the up, down, load and clear requests, advances the counter register at a prescaled rate, and saturates or wraps at the range limits. It also flags loaded values that fall outside the legal range. It sits between the debounced front-panel inputs and the display/decoding stage, and owns the `Compteurs` register and its out-of-range flag.

## Interface
- `TICK_DIV`, 4: clock cycles per count step while running (≥1).
- `VAL_MAX`, 999: upper legal value; lower legal value is fixed at 0.
- `WRAP`, 0: 0 = saturate at limits, 1 = wrap 999↔0.
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `BoutonHaut` in 1: level; hold to count up.
- `BoutonBas` in 1: level; hold to count down.
- `Charger` in 1: single-cycle load strobe.
- `ValeurCharge` in 12 signed: value loaded on `Charger`.
- `Effacer` in 1: single-cycle clear strobe.
- `Compteurs` out 12 signed: counter value, registered.
- `CompteursHorsPlage` out 1: registered; 1 when `Compteurs` < 0 or > `VAL_MAX`.
- `Limite` out 1: one-cycle pulse when a step hits a limit (saturate or wrap).
- `Etat` out 2: current FSM state encoding.

## Operation
- States:
  - IDLE=0: no stepping.
  - HAUT=1: counting up.
  - BAS=2: counting down.
  - DEFAUT=3: value out of range; stepping blocked.
- Request priority per cycle: `Effacer` > `Charger` > direction inputs.
- `Effacer`, from any state: `Compteurs`←0, `CompteursHorsPlage`←0, go to IDLE, clear the prescaler.
- `Charger`, from any state:
  - `Compteurs`←`ValeurCharge`.
  - If `ValeurCharge` is in 0..`VAL_MAX`: go to IDLE, `CompteursHorsPlage`←0.
  - Otherwise: go to DEFAUT, `CompteursHorsPlage`←1.
- From IDLE, HAUT or BAS:
  - `BoutonHaut` & !`BoutonBas` → HAUT.
  - `BoutonBas` & !`BoutonHaut` → BAS.
  - Both high or both low → IDLE.
- DEFAUT ignores `BoutonHaut` and `BoutonBas`. It is left only via `Effacer` or a valid `Charger`.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 while in HAUT or BAS.
  - Resets to 0 on every state change.
  - A step occurs on the cycle the prescaler equals `TICK_DIV`-1.
- Step in HAUT:
  - Below `VAL_MAX`: +1.
  - At `VAL_MAX`: stays at `VAL_MAX` (WRAP=0) or goes to 0 (WRAP=1); `Limite`=1 for that cycle.
- Step in BAS:
  - Above 0: −1.
  - At 0: stays at 0 (WRAP=0) or goes to `VAL_MAX` (WRAP=1); `Limite`=1 for that cycle.
- Arithmetic: 12-bit signed; results are never out of range during stepping.
- `CompteursHorsPlage` is recomputed from the next value on every `Compteurs` update.

## Timing
- Reset values: `Compteurs`=0, `CompteursHorsPlage`=0, `Limite`=0, `Etat`=IDLE, prescaler=0.
- Reset asserted mid-count takes effect immediately (asynchronous). Operation restarts from IDLE on the first edge after deassertion.
- Request latency: a request sampled at edge N changes `Etat` at edge N.
- First step latency: the first step lands `TICK_DIV` edges after entry to HAUT or BAS.
- With `TICK_DIV`=1, every cycle in HAUT or BAS is a step.
- `Charger` and `Effacer` update `Compteurs` on the sampling edge; zero-cycle latency to the registered output.
- Simultaneous events:
  - `Charger` + `Effacer` → clear wins.
  - `Charger` while counting → load wins; no step that cycle.
- Direction reversal (HAUT→BAS) restarts the prescaler; no step is issued in the reversal cycle.
- `Limite` is asserted in the same cycle as the `Compteurs` update that hits the limit.
- In saturate mode, `Limite` re-pulses on every further step while the button is held at the limit.

## Structure
- Package `controleur_compteur_pkg`:
  - State enum `etat_t` (IDLE, HAUT, BAS, DEFAUT).
  - Constants `LARGEUR`=12 and default `VAL_MAX`.
  - Helper function `hors_plage(val)`.
- Sub-module `diviseur_tick`: prescaler with synchronous clear input and one-cycle tick output, parameterised by `TICK_DIV`.
- The FSM, arbitration and counter register live in the top module.

## Test plan
- Reset then `BoutonHaut` held 40 cycles, `TICK_DIV`=4 → `Compteurs` reaches 10. First increment occurs 4 cycles after `Etat`=HAUT.
- `Charger` with 998, then `BoutonHaut` held 12 cycles, WRAP=0 → `Compteurs` reads 999, 999. `Limite` pulses on the 2nd and 3rd steps. `CompteursHorsPlage` stays 0.
- WRAP=1: `Charger` with 0, then `BoutonBas` for 1 step → `Compteurs`=999 and `Limite`=1 for one cycle.
- `Charger` with −5 → `Etat`=DEFAUT, `CompteursHorsPlage`=1, buttons ignored. `Charger` with 1200 → still DEFAUT. `Charger` with 500 → IDLE, flag 0.
- `BoutonHaut` and `BoutonBas` both high → `Etat`=IDLE, value unchanged. `Charger`+`Effacer` in the same cycle → `Compteurs`=0.
- `Reset_n` pulsed low between clock edges during counting → outputs are 0 and IDLE immediately, without waiting for `Clk`.
